hash_result_arbiter: RTL and testbench



---
 rtl/hash_result_arbiter.sv | 149 ++++++++++++++
 tb/tb_hash_result_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_result_arbiter.sv
// Round-robin merge of NUM_SRC hash-result streams onto one registered bus slice.
// A winning source keeps the bus until its delim beat is accepted.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef HASH_ISSUE_WIDTH
`define HASH_ISSUE_WIDTH 1
`endif
`ifndef META_MATCH_LEN_WIDTH
`define META_MATCH_LEN_WIDTH 5
`endif

module hash_result_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC),
  parameter int W       = `ADDR_WIDTH + `HASH_ISSUE_WIDTH*(`ADDR_WIDTH+`META_MATCH_LEN_WIDTH+1+8)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   i_valid,
  input  logic [NUM_SRC*W-1:0] i_payload,
  input  logic [NUM_SRC-1:0]   i_delim,
  output logic [NUM_SRC-1:0]   i_ready,
  output logic                 o_valid,
  output logic [W-1:0]         o_payload,
  output logic                 o_delim,
  output logic [SRC_W-1:0]     o_src_idx,
  input  logic                 o_ready,
  output logic                 o_locked
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t               r_state, w_state_nxt;
  logic [SRC_W-1:0]     r_owner, w_owner_nxt;
  logic [SRC_W-1:0]     r_rr_ptr, w_rr_nxt;
  logic [SRC_W-1:0]     w_win;
  logic                 w_win_vld;
  logic                 w_slot_free;
  logic                 w_accept;
  logic                 w_win_in_vld;
  logic                 w_win_delim;
  logic [W-1:0]         w_win_payload;
  logic [2*NUM_SRC-1:0] w_rot;

  function automatic logic [SRC_W-1:0] f_inc(input logic [SRC_W-1:0] x);
    if (x == SRC_W'(NUM_SRC-1)) return '0;
    return x + SRC_W'(1);
  endfunction

  function automatic logic [SRC_W-1:0] f_add(input logic [SRC_W-1:0] a, input int k);
    logic [SRC_W:0] s;
    s = {1'b0, a} + (SRC_W+1)'(k);
    if (s >= (SRC_W+1)'(NUM_SRC)) s = s - (SRC_W+1)'(NUM_SRC);
    return s[SRC_W-1:0];
  endfunction

  assign w_slot_free = !o_valid || o_ready;
  assign w_rot       = {i_valid, i_valid} >> r_rr_ptr;

  // Scan from the highest rotated offset down so the nearest valid to rr_ptr wins.
  always_comb begin
    w_win     = r_owner;
    w_win_vld = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_win_vld = 1'b1;
    end else begin
      for (int k = NUM_SRC-1; k >= 0; k--) begin
        if (w_rot[k]) begin
          w_win     = f_add(r_rr_ptr, k);
          w_win_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_win_payload = '0;
    w_win_delim   = 1'b0;
    w_win_in_vld  = 1'b0;
    i_ready       = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (w_win == SRC_W'(s)) begin
        w_win_payload = i_payload[s*W +: W];
        w_win_delim   = i_delim[s];
        w_win_in_vld  = i_valid[s];
        i_ready[s]    = !rst && w_slot_free && w_win_vld;
      end
    end
  end

  assign w_accept = w_win_in_vld && (|i_ready);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_delim) begin
            w_rr_nxt = f_inc(w_win);
          end else begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_win;
          end
        end
        ST_LOCKED: begin
          if (w_win_delim) begin
            w_state_nxt = ST_IDLE;
            w_rr_nxt    = f_inc(r_owner);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid   <= 1'b0;
      o_payload <= '0;
      o_delim   <= 1'b0;
      o_src_idx <= '0;
    end else if (w_accept) begin
      o_valid   <= 1'b1;
      o_payload <= w_win_payload;
      o_delim   <= w_win_delim;
      o_src_idx <= w_win;
    end else if (o_ready) begin
      o_valid   <= 1'b0;
    end
  end

  assign o_locked = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_hash_result_arbiter.sv
// Scoreboard bench for hash_result_arbiter: per-source beat queues feed the DUT,
// expected output order is queued by each scenario and checked as beats drain.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef HASH_ISSUE_WIDTH
`define HASH_ISSUE_WIDTH 1
`endif
`ifndef META_MATCH_LEN_WIDTH
`define META_MATCH_LEN_WIDTH 5
`endif

module tb_hash_result_arbiter;
  localparam int NUM_SRC = 4;
  localparam int SRC_W   = 2;
  localparam int W       = `ADDR_WIDTH + `HASH_ISSUE_WIDTH*(`ADDR_WIDTH+`META_MATCH_LEN_WIDTH+1+8);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_SRC-1:0]   i_valid = '0;
  logic [NUM_SRC*W-1:0] i_payload = '0;
  logic [NUM_SRC-1:0]   i_delim = '0;
  logic [NUM_SRC-1:0]   i_ready;
  logic                 o_valid;
  logic [W-1:0]         o_payload;
  logic                 o_delim;
  logic [SRC_W-1:0]     o_src_idx;
  logic                 o_ready = 1'b1;
  logic                 o_locked;

  typedef struct packed { logic [W-1:0] p; logic d; } beat_t;
  typedef struct packed { logic [SRC_W-1:0] s; logic [W-1:0] p; logic d; } exp_t;

  beat_t              src_q[NUM_SRC][$];
  exp_t               exp_q[$];
  logic               drv_en = 1'b0;
  logic [NUM_SRC-1:0] stall = '0;
  logic [NUM_SRC-1:0] acc_pend = '0;
  int                 ncyc = 0;
  int                 checks = 0;
  int                 errors = 0;

  hash_result_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .W(W)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_payload(i_payload), .i_delim(i_delim), .i_ready(i_ready),
    .o_valid(o_valid), .o_payload(o_payload), .o_delim(o_delim), .o_src_idx(o_src_idx),
    .o_ready(o_ready), .o_locked(o_locked)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(int s, int j, int b);
    return W'({8'(s), 8'(j), 8'(b)});
  endfunction

  task automatic job(int s, int j, int nb);
    beat_t bt;
    for (int b = 0; b < nb; b++) begin
      bt.p = mk(s, j, b);
      bt.d = (b == nb-1);
      src_q[s].push_back(bt);
    end
  endtask

  task automatic expect_job(int s, int j, int nb);
    exp_t e;
    for (int b = 0; b < nb; b++) begin
      e.s = SRC_W'(s);
      e.p = mk(s, j, b);
      e.d = (b == nb-1);
      exp_q.push_back(e);
    end
  endtask

  task automatic flush();
    for (int s = 0; s < NUM_SRC; s++) src_q[s].delete();
    exp_q.delete();
    acc_pend = '0;
  endtask

  // Negedge: retire accepted source beats, score the output beat about to
  // transfer, drive the next source heads, then latch what the coming edge accepts.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (drv_en)
        for (int s = 0; s < NUM_SRC; s++)
          if (acc_pend[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
      if (!rst) begin
        checks++;
        if (!$onehot0(i_ready)) begin
          errors++;
          $display("FAIL ready_onehot: i_ready=%b required at most one bit", i_ready);
        end
        if (o_valid && o_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: src=%0d payload=%0h required no beat", o_src_idx, o_payload);
          end else begin
            e = exp_q.pop_front();
            if ({o_src_idx, o_payload, o_delim, o_locked} !== {e.s, e.p, e.d, !e.d}) begin
              errors++;
              $display("FAIL out_beat: src=%0d payload=%0h delim=%b locked=%b required src=%0d payload=%0h delim=%b locked=%b",
                       o_src_idx, o_payload, o_delim, o_locked, e.s, e.p, e.d, !e.d);
            end
          end
        end
      end
      if (drv_en)
        for (int s = 0; s < NUM_SRC; s++) begin
          if (src_q[s].size() > 0) begin
            i_valid[s]           = !stall[s];
            i_payload[s*W +: W]  = src_q[s][0].p;
            i_delim[s]           = src_q[s][0].d;
          end else begin
            i_valid[s] = 1'b0;
          end
        end
      #1 acc_pend = i_valid & i_ready;
    end
  end

  task automatic wait_drain(string nm);
    int n;
    bit busy;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
      busy = (exp_q.size() != 0);
      for (int s = 0; s < NUM_SRC; s++) if (src_q[s].size() != 0) busy = 1'b1;
    end while (busy && n < 300);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", nm, exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    flush();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; o_ready = 1'b1; i_valid = '0; i_payload = '0; i_delim = '0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({o_valid, o_payload, o_delim, o_src_idx, o_locked, i_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%b p=%0h d=%b idx=%0d lk=%b rdy=%b required all 0",
               o_valid, o_payload, o_delim, o_src_idx, o_locked, i_ready);
    end
    i_valid = 4'b0100;
    i_payload[2*W +: W] = W'(8'h5A);
    i_delim[2] = 1'b1;
    #1;
    checks++;
    if (i_ready !== 4'b0000) begin
      errors++;
      $display("FAIL ready_in_reset: i_ready=%b required 0000", i_ready);
    end
    e.s = 2'd2; e.p = W'(8'h5A); e.d = 1'b1;
    exp_q.push_back(e);
    rst = 1'b0;
    #1;
    checks++;
    if (i_ready !== 4'b0100) begin
      errors++;
      $display("FAIL first_ready: i_ready=%b required 0100", i_ready);
    end
    @(posedge clk); #1;
    i_valid = '0;
    #1;
    checks++;
    if ({o_valid, o_payload, o_src_idx} !== {1'b1, W'(8'h5A), 2'd2}) begin
      errors++;
      $display("FAIL first_beat: v=%b p=%0h idx=%0d required v=1 p=5a idx=2", o_valid, o_payload, o_src_idx);
    end
    @(posedge clk); #2;
    drv_en = 1'b1;
    wait_drain("reset");
  endtask

  task automatic test_round_robin();
    int c0;
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < NUM_SRC; s++) begin
        job(s, r, 1);
        expect_job(s, r, 1);
      end
    c0 = ncyc;
    wait_drain("round_robin");
    checks++;
    if (ncyc - c0 != 13) begin
      errors++;
      $display("FAIL rr_throughput: %0d cycles for 12 beats, required 13", ncyc - c0);
    end
  endtask

  task automatic test_lock_hold();
    job(0, 1, 1); job(1, 2, 3); job(2, 3, 1); job(0, 4, 1);
    expect_job(0, 1, 1); expect_job(1, 2, 3); expect_job(2, 3, 1); expect_job(0, 4, 1);
    wait_drain("lock_hold");
  endtask

  task automatic test_backpressure();
    int n;
    job(1, 5, 6); job(2, 6, 1);
    expect_job(1, 5, 6); expect_job(2, 6, 1);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (exp_q.size() > 6 && n < 50);
    o_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #2;
      checks++;
      if (exp_q.size() == 0 || o_valid !== 1'b1 || o_payload !== exp_q[0].p) begin
        errors++;
        $display("FAIL bp_hold: v=%b p=%0h required v=1 p=%0h", o_valid, o_payload,
                 (exp_q.size() != 0) ? exp_q[0].p : '0);
      end
      checks++;
      if (i_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready: i_ready=%b required 0000", i_ready);
      end
    end
    o_ready = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_midjob_reset();
    int n;
    job(2, 7, 4);
    expect_job(2, 7, 4);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (exp_q.size() > 3 && n < 50);
    checks++;
    if ({o_valid, o_locked} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_lock: v=%b lk=%b required 11", o_valid, o_locked);
    end
    rst = 1'b1;
    flush();
    #1;
    checks++;
    if ({o_valid, o_locked, i_ready} !== 6'b0) begin
      errors++;
      $display("FAIL midjob_reset: v=%b lk=%b rdy=%b required 0 0 0000", o_valid, o_locked, i_ready);
    end
    @(posedge clk); #2;
    checks++;
    if ({o_valid, o_locked} !== 2'b00) begin
      errors++;
      $display("FAIL reset_next_cycle: v=%b lk=%b required 00", o_valid, o_locked);
    end
    rst = 1'b0;
    job(1, 8, 1); job(3, 9, 1);
    expect_job(1, 8, 1); expect_job(3, 9, 1);
    wait_drain("midjob_reset");
  endtask

  task automatic test_owner_bubble();
    int n;
    job(0, 10, 4); job(2, 11, 1); job(3, 12, 1);
    expect_job(0, 10, 4); expect_job(2, 11, 1); expect_job(3, 12, 1);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (exp_q.size() > 5 && n < 50);
    stall[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      checks++;
      if (i_ready[3:1] !== 3'b000 || o_locked !== 1'b1) begin
        errors++;
        $display("FAIL bubble_block: i_ready=%b lk=%b required ready[3:1]=000 lk=1", i_ready, o_locked);
      end
    end
    stall[0] = 1'b0;
    wait_drain("owner_bubble");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_lock_hold();
    test_backpressure();
    test_midjob_reset();
    test_owner_bubble();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
